// File: rtl/nios_system_led.sv
// -----------------------------------------------------------------------------
// nios_system_led
//
// Purpose:
//   Avalon-MM slave driving a bank of LED/pin outputs. A DATA register sets the
//   static pattern. An optional blink engine XORs a BLINK_MASK onto that
//   pattern whenever its phase bit is set. The phase toggles every PERIOD+1
//   clock cycles.
//
// Register map (word addresses):
//   0 DATA       R/W  [DATA_WIDTH-1:0]
//   1 BLINK_MASK R/W  [DATA_WIDTH-1:0]
//   2 PERIOD     R/W  [15:0]
//   3 STATUS     RO   bit0 = phase, [31:16] = down-counter
//   Bits not listed read as 0.
//
// Configuration macro:
//   NIOS_SYSTEM_LED_BLINK_EN
//     Defined:   the blink engine (BLINK_MASK, PERIOD, counter, phase) is built.
//     Undefined: no blink flops are built. Addresses 1-3 read 0 and ignore
//                writes, and out_port follows DATA directly.
//
// Parameters:
//   DATA_WIDTH    out_port width, 1..16
//   PERIOD_RESET  reset value of PERIOD and of the blink counter
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   reset_n     asynchronous, active-low reset
//   address     Avalon-MM word address
//   chipselect  slave select; no write happens without it
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   write data
//   readdata    registered read data (latency 1, independent of chipselect)
//   out_port    LED/pin outputs
// -----------------------------------------------------------------------------
module nios_system_led #(
  parameter int          DATA_WIDTH   = 10,
  parameter logic [15:0] PERIOD_RESET = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;
  localparam int         PAD_WIDTH   = 32 - DATA_WIDTH;

  logic                  w_write;
  logic                  w_writeData;
  logic [31:0]           w_readMux;
  logic [31:0]           w_dataExt;
  logic                  w_unusedWriteBits;

  logic [DATA_WIDTH-1:0] r_data;
  logic [31:0]           r_readdata;

  assign w_write     = chipselect & ~write_n;
  assign w_writeData = w_write && (address == ADDR_DATA);
  assign w_dataExt   = {{PAD_WIDTH{1'b0}}, r_data};

  // Only the low bits of writedata reach a register. The upper bits are
  // collected here so they are visibly accounted for.
  assign w_unusedWriteBits = ^writedata;

  // DATA register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
    end else if (w_writeData) begin
      r_data <= writedata[DATA_WIDTH-1:0];
    end
  end

`ifdef NIOS_SYSTEM_LED_BLINK_EN

  logic                  w_writeMask;
  logic                  w_writePeriod;
  logic [15:0]           w_counterNext;
  logic                  w_phaseNext;
  logic [31:0]           w_status;

  logic [DATA_WIDTH-1:0] r_blinkMask;
  logic [15:0]           r_period;
  logic [15:0]           r_counter;
  logic                  r_phase;

  assign w_writeMask   = w_write && (address == ADDR_MASK);
  assign w_writePeriod = w_write && (address == ADDR_PERIOD);
  assign w_status      = {r_counter, 15'h0000, r_phase};

  // BLINK_MASK and PERIOD registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blinkMask <= '0;
      r_period    <= PERIOD_RESET;
    end else begin
      if (w_writeMask) begin
        r_blinkMask <= writedata[DATA_WIDTH-1:0];
      end
      if (w_writePeriod) begin
        r_period <= writedata[15:0];
      end
    end
  end

  // Blink engine next state. A PERIOD write restarts the count from the new
  // value with phase cleared, and it overrides any toggle or reload due on the
  // same edge. Reloading on zero, rather than decrementing through it, gives a
  // toggle every PERIOD+1 cycles. This holds up to and including 16'hFFFF.
  always_comb begin
    w_counterNext = r_counter;
    w_phaseNext   = r_phase;
    if (w_writePeriod) begin
      w_counterNext = writedata[15:0];
      w_phaseNext   = 1'b0;
    end else if (r_period == 16'h0000) begin
      w_counterNext = 16'h0000;
      w_phaseNext   = 1'b0;
    end else if (r_counter != 16'h0000) begin
      w_counterNext = r_counter - 16'd1;
    end else begin
      w_counterNext = r_period;
      w_phaseNext   = ~r_phase;
    end
  end

  // Blink engine state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_counter <= PERIOD_RESET;
      r_phase   <= 1'b0;
    end else begin
      r_counter <= w_counterNext;
      r_phase   <= w_phaseNext;
    end
  end

  // Read selection uses the values from before this edge's write.
  always_comb begin
    w_readMux = 32'h0000_0000;
    case (address)
      ADDR_DATA:   w_readMux = w_dataExt;
      ADDR_MASK:   w_readMux = {{PAD_WIDTH{1'b0}}, r_blinkMask};
      ADDR_PERIOD: w_readMux = {16'h0000, r_period};
      ADDR_STATUS: w_readMux = w_status;
      default:     w_readMux = 32'h0000_0000;
    endcase
  end

  // out_port is built only from flops, so there are no glitches from bus inputs.
  assign out_port = r_data ^ (r_blinkMask & {DATA_WIDTH{r_phase}});

`else

  // No blink engine: only DATA is readable, and everything else reads as 0.
  always_comb begin
    w_readMux = 32'h0000_0000;
    if (address == ADDR_DATA) begin
      w_readMux = w_dataExt;
    end
  end

  assign out_port = r_data;

`endif

  // Registered read port. It updates every cycle, whether or not chipselect
  // is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'h0000_0000;
    end else begin
      r_readdata <= w_readMux;
    end
  end

  assign readdata = r_readdata;

endmodule

// File: tb/tb_nios_system_led.sv
// -----------------------------------------------------------------------------
// tb_nios_system_led
//
// Directed testbench for nios_system_led. It uses DATA_WIDTH=10 and
// PERIOD_RESET=16'h0007. When NIOS_SYSTEM_LED_BLINK_EN is defined, it checks
// the blink engine. Otherwise it checks the reduced DATA-only build.
// -----------------------------------------------------------------------------
module tb_nios_system_led;

  localparam int          DW = 10;
  localparam logic [15:0] PR = 16'h0007;

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;

  int            checkCount = 0;
  int            errorCount = 0;
  logic [31:0]   rdValue;
  logic [31:0]   expOut;

  nios_system_led #(
    .DATA_WIDTH  (DW),
    .PERIOD_RESET(PR)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  // Clock with a 10 ns period. Rising edges fall at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One bus write. The task returns 1 ns after the write edge.
  task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // One read. readdata is sampled 1 ns after the edge that registers it.
  task automatic readReg(input logic [1:0] addr, output logic [31:0] value);
    address = addr;
    @(posedge clk);
    #1;
    value = readdata;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;

    #3;
    checkOutput("reset_out", 32'(out_port), 32'h0);
    checkOutput("reset_rd", readdata, 32'h0);
    #9;
    reset_n = 1'b1;

`ifdef NIOS_SYSTEM_LED_BLINK_EN
    readReg(2'd2, rdValue);
    checkOutput("period_rst", rdValue, 32'h0000_0007);
    readReg(2'd1, rdValue);
    checkOutput("mask_rst", rdValue, 32'h0);
    readReg(2'd0, rdValue);
    checkOutput("data_rst", rdValue, 32'h0);

    // DATA path
    applyStimulus(2'd0, 32'h0000_02A5);
    checkOutput("data_out", 32'(out_port), 32'h2A5);
    readReg(2'd0, rdValue);
    checkOutput("data_rd", rdValue, 32'h0000_02A5);

    // readdata shows the old value on the write edge
    applyStimulus(2'd0, 32'h0000_0111);
    checkOutput("rd_prewrite", readdata, 32'h0000_02A5);
    checkOutput("data_out2", 32'(out_port), 32'h111);
    readReg(2'd0, rdValue);
    checkOutput("data_rd2", rdValue, 32'h0000_0111);
    applyStimulus(2'd0, 32'h0000_02A5);

    // Idle the engine, then check the mask width and the unused bits
    applyStimulus(2'd2, 32'h0);
    readReg(2'd3, rdValue);
    checkOutput("status_idle", rdValue, 32'h0);
    applyStimulus(2'd1, 32'hFFFF_FFFF);
    readReg(2'd1, rdValue);
    checkOutput("mask_width", rdValue, 32'h0000_03FF);
    checkOutput("out_phase0", 32'(out_port), 32'h2A5);
    applyStimulus(2'd1, 32'h0000_0003);

    // Blink timing: PERIOD=3 gives a toggle every 4 cycles
    applyStimulus(2'd2, 32'h0000_0003);
    checkOutput("blink_k0", 32'(out_port), 32'h2A5);
    for (int k = 1; k <= 13; k++) begin
      stepCycles(1);
      expOut = (((k / 4) % 2) == 1) ? 32'h2A6 : 32'h2A5;
      checkOutput($sformatf("blink_k%0d", k), 32'(out_port), expOut);
    end
    // Counter is now 2 and phase is 1. STATUS is captured on the next edge.
    address = 2'd3;
    stepCycles(1);
    checkOutput("status_run", readdata, 32'h0002_0001);

    // A PERIOD write of 0 during phase=1 clears phase and idles the engine
    applyStimulus(2'd2, 32'h0);
    checkOutput("mid_period_out", 32'(out_port), 32'h2A5);
    readReg(2'd3, rdValue);
    checkOutput("mid_period_status", rdValue, 32'h0);

    // STATUS is read-only
    applyStimulus(2'd3, 32'hFFFF_FFFF);
    readReg(2'd3, rdValue);
    checkOutput("status_ro", rdValue, 32'h0);
    readReg(2'd2, rdValue);
    checkOutput("period_keep", rdValue, 32'h0);

    // Collision: a DATA write lands on the toggle edge
    applyStimulus(2'd2, 32'h0000_0001);
    stepCycles(1);
    checkOutput("coll_pre", 32'(out_port), 32'h2A5);
    applyStimulus(2'd0, 32'h0000_0155);
    checkOutput("coll_edge", 32'(out_port), 32'h156);
    stepCycles(1);
    checkOutput("coll_hold", 32'(out_port), 32'h156);
    stepCycles(1);
    checkOutput("coll_back", 32'(out_port), 32'h155);

    // A PERIOD write on a toggle edge overrides the toggle
    stepCycles(1);
    applyStimulus(2'd2, 32'h0000_0005);
    checkOutput("period_override", 32'(out_port), 32'h155);
    readReg(2'd3, rdValue);
    checkOutput("period_load", rdValue, 32'h0005_0000);
    stepCycles(5);
    checkOutput("blink5_on", 32'(out_port), 32'h156);

    // Reset mid-blink, then the count restarts from PERIOD_RESET
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_out", 32'(out_port), 32'h0);
    checkOutput("midrst_rd", readdata, 32'h0);
    #2;
    reset_n = 1'b1;
    readReg(2'd3, rdValue);
    checkOutput("restart_status", rdValue, 32'h0007_0000);
    readReg(2'd2, rdValue);
    checkOutput("restart_period", rdValue, 32'h0000_0007);
    readReg(2'd0, rdValue);
    checkOutput("restart_data", rdValue, 32'h0);

    // Largest PERIOD: the counter starts at FFFF and counts down
    applyStimulus(2'd2, 32'h0000_FFFF);
    readReg(2'd3, rdValue);
    checkOutput("ffff_load", rdValue, 32'hFFFF_0000);
    readReg(2'd3, rdValue);
    checkOutput("ffff_dec", rdValue, 32'hFFFE_0000);
`else
    readReg(2'd2, rdValue);
    checkOutput("noblink_period_rst", rdValue, 32'h0);

    applyStimulus(2'd0, 32'h0000_02A5);
    checkOutput("data_out", 32'(out_port), 32'h2A5);
    readReg(2'd0, rdValue);
    checkOutput("data_rd", rdValue, 32'h0000_02A5);

    applyStimulus(2'd0, 32'h0000_0111);
    checkOutput("rd_prewrite", readdata, 32'h0000_02A5);
    checkOutput("data_out2", 32'(out_port), 32'h111);
    applyStimulus(2'd0, 32'h0000_02A5);

    applyStimulus(2'd1, 32'h0000_03FF);
    applyStimulus(2'd2, 32'h0000_0005);
    readReg(2'd1, rdValue);
    checkOutput("noblink_mask_rd", rdValue, 32'h0);
    readReg(2'd2, rdValue);
    checkOutput("noblink_period_rd", rdValue, 32'h0);
    readReg(2'd3, rdValue);
    checkOutput("noblink_status_rd", rdValue, 32'h0);
    checkOutput("noblink_out", 32'(out_port), 32'h2A5);
    stepCycles(12);
    checkOutput("noblink_out_later", 32'(out_port), 32'h2A5);

    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_out", 32'(out_port), 32'h0);
    checkOutput("midrst_rd", readdata, 32'h0);
    #2;
    reset_n = 1'b1;
    readReg(2'd0, rdValue);
    checkOutput("restart_data", rdValue, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/nios_system_led.md
NIOS_SYSTEM_LED -- requirements
Module: nios_system_led

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 10, giving the out_port width (1..16).
REQ-002 The block SHALL have parameter PERIOD_RESET, default 16'h0000, giving the PERIOD register reset value.
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all state on rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port address, input, 2 bits: Avalon-MM word address.
REQ-006 The block SHALL have port chipselect, input, 1 bit: slave select; no access without it.
REQ-007 The block SHALL have port write_n, input, 1 bit: active-low write strobe, qualified by chipselect.
REQ-008 The block SHALL have port writedata, input, 32 bits: write data.
REQ-009 The block SHALL have port readdata, output, 32 bits: registered read data.
REQ-010 The block SHALL have port out_port, output, DATA_WIDTH bits: driven LED/pin outputs.

Function
REQ-011 The block SHALL use this register map: 0 DATA (R/W, [DATA_WIDTH-1:0]); 1 BLINK_MASK (R/W, [DATA_WIDTH-1:0]); 2 PERIOD (R/W, [15:0]); 3 STATUS (RO: bit0 phase, [31:16] counter). Unused bits SHALL read 0.
REQ-012 A write SHALL occur on a rising edge with chipselect=1 and write_n=0; the target register SHALL hold the new value from the next cycle on.
REQ-013 Writes to address 3 SHALL be ignored.
REQ-014 readdata SHALL update every cycle with the selected register value, independent of chipselect, giving a read latency of 1 cycle.
REQ-015 readdata SHALL show the register value before a write on the same edge, not the value being written.
REQ-016 out_port SHALL equal DATA XOR (BLINK_MASK AND {DATA_WIDTH{phase}}), taken from flops only, so a DATA write is visible on out_port 1 cycle after the write edge.
REQ-017 Blink engine: 16-bit down-counter plus 1-bit phase.
  - PERIOD=0: counter=0 and phase=0 held; engine idle.
  - PERIOD!=0, counter!=0: counter decrements by 1.
  - PERIOD!=0, counter==0: phase toggles and counter reloads PERIOD.
  - Result: phase toggles every PERIOD+1 cycles.
REQ-018 A PERIOD write SHALL load counter with the new writedata[15:0] and clear phase on the same edge, overriding any toggle/reload due that cycle.
REQ-019 A DATA or BLINK_MASK write that coincides with a phase toggle SHALL have both effects applied; out_port next cycle SHALL reflect the new register and the new phase.
REQ-020 The counter SHALL never wrap below 0; with PERIOD=16'hFFFF the toggle interval SHALL be exactly 65536 cycles.

Reset
REQ-021 While reset_n=0 (asynchronous assert): DATA=0, BLINK_MASK=0, PERIOD=PERIOD_RESET, counter=PERIOD_RESET, phase=0, readdata=0, out_port=0.
REQ-022 Reset asserted mid-blink SHALL abandon the count; after release, counting SHALL restart from PERIOD_RESET with phase=0.

Configuration
REQ-023 With macro NIOS_SYSTEM_LED_BLINK_EN defined, the blink engine (BLINK_MASK, PERIOD, counter, phase) SHALL be built as specified.
REQ-024 With NIOS_SYSTEM_LED_BLINK_EN undefined:
  - No blink flops SHALL be built.
  - Addresses 1-3 SHALL read 0 and ignore writes.
  - out_port SHALL equal DATA.

Verification
REQ-025 Reset check: assert reset_n=0 mid-run -> out_port=0 and readdata=0 immediately; after release, read addr 2 -> PERIOD_RESET.
REQ-026 DATA path: write DATA=0x2A5 -> out_port=0x2A5 one cycle later; read addr 0 -> readdata=0x000002A5 with latency 1.
REQ-027 Blink timing: write BLINK_MASK=0x003, then PERIOD=3, with DATA=0x2A5 -> out_port alternates 0x2A5/0x2A6 every 4 cycles, first toggle 4 cycles after the PERIOD write.
REQ-028 Mid-blink PERIOD write: during phase=1, write PERIOD=0 -> phase=0 next cycle, out_port=DATA, STATUS reads 0.
REQ-029 Collision: DATA write lands on the toggle edge -> out_port next cycle = newDATA XOR (mask AND new phase).
REQ-030 Config: build without NIOS_SYSTEM_LED_BLINK_EN; write addr 1=0x3FF and addr 2=5 -> both read 0, out_port=DATA unchanged.
